countdown_timer_ctrl: RTL and testbench
=======================================

COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: input clock frequency; one second equals CLK_HZ cycles.
REQ-002 Parameter MAX_MIN, default 99, range 1..99: upper saturation limit for minutes.
REQ-003 Parameter DB_CYCLES, default 1_000_000: cycles a synchronised button level must stay stable before it is accepted.
REQ-004 Parameter REFRESH_BITS, default 17: each digit is displayed for 2^REFRESH_BITS cycles.
REQ-005 clk  in  1  single system clock; all state is on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 btn_start  in  1  start/pause/acknowledge button, asynchronous, active-high.
REQ-008 btn_dec  in  1  decrement-minute button, asynchronous, active-high.
REQ-009 btn_inc  in  1  increment-minute button, asynchronous, active-high.
REQ-010 btn_clr  in  1  clear button, asynchronous, active-high.
REQ-011 hold  in  1  when high, all button events are suppressed and the debouncers are held cleared.
REQ-012 an  out  4  digit anodes, active-low; an[3] is the leftmost digit.
REQ-013 seg  out  7  cathodes {g..a}, active-low.
REQ-014 dp  out  1  decimal point, active-low.
REQ-015 running  out  1  high in RUN.
REQ-016 expired  out  1  high in EXPIRED.

Function
REQ-017 Each button SHALL pass a 2-flop synchroniser, then a debouncer that accepts a new level after DB_CYCLES consecutive equal samples; an accepted 0->1 transition SHALL produce a single one-cycle event pulse.
REQ-018 State machine SHALL have four states: IDLE, RUN, PAUSE, EXPIRED.
REQ-019 Same-cycle event priority SHALL be clr > start > inc > dec; at most one event SHALL act per cycle.
REQ-020 The clr event SHALL move the block from any state to IDLE with minutes=0 and seconds=0.
REQ-021 start in IDLE or PAUSE SHALL enter RUN when time is nonzero; at 00:00 it SHALL be ignored.
REQ-022 start in RUN SHALL enter PAUSE; start in EXPIRED SHALL enter IDLE, leaving time at 00:00.
REQ-023 inc/dec SHALL act only in IDLE and PAUSE and SHALL change minutes only.
REQ-024 inc SHALL saturate at MAX_MIN; dec at minutes=0 SHALL have no effect, with no wrap.
REQ-025 Prescaler SHALL count 0..CLK_HZ-1 only in RUN and SHALL be cleared in every other state, so the first decrement occurs exactly CLK_HZ cycles after entering RUN.
REQ-026 On a tick with seconds>0, seconds SHALL decrement; with seconds=0 and minutes>0, minutes SHALL decrement and seconds SHALL become 59.
REQ-027 A tick that produces 00:00 SHALL move the state to EXPIRED in the same cycle the time is updated.
REQ-028 Widths SHALL be 7-bit minutes and 6-bit seconds; seconds SHALL never exceed 59 and minutes SHALL never exceed MAX_MIN.
REQ-029 A 2-bit digit index SHALL advance every 2^REFRESH_BITS cycles and SHALL select an = 0111, 1011, 1101, 1110, showing minute tens, minute units, second tens and second units respectively.
REQ-030 Digit values SHALL be encoded (active-low, gfedcba) as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-031 dp SHALL be 0 only while the minute-units digit is selected and the state is not IDLE; otherwise it SHALL be 1.
REQ-032 In EXPIRED, a blink flag SHALL toggle every CLK_HZ/2 cycles; while the flag is 0, an SHALL be 1111.
REQ-033 Anode and seg outputs SHALL be registered; seg SHALL change in the same cycle as an.
REQ-034 When hold rises mid-RUN, the countdown SHALL continue; only button events are suppressed.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, time 00:00, prescaler 0, debouncers 0, digit index 0, blink 0.
REQ-036 rst_n low SHALL drive an=0111, seg=1000000, dp=1, running=0, expired=0.
REQ-037 Deassertion of rst_n mid-count SHALL not resume the count; operation SHALL restart from IDLE.

Verification (CLK_HZ=10, DB_CYCLES=2, REFRESH_BITS=2, MAX_MIN=99)
REQ-038 inc x2, start -> running=1; first decrement at exactly 10 cycles, shown as 01:59.
REQ-039 inc x1, start, run 600 cycles -> 00:00, expired=1, an blinks 1111 every 5 cycles; start then gives IDLE with expired=0.
REQ-040 inc x100 -> minutes=99; dec x100 -> minutes=0; start at 00:00 -> state stays IDLE.
REQ-041 clr and start pressed in the same cycle during RUN -> IDLE at 00:00, running=0.
REQ-042 Button bounce shorter than DB_CYCLES -> no event; hold=1 with an inc press -> minutes unchanged.
REQ-043 rst_n pulsed low mid-RUN -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
//   Minutes:seconds countdown timer with four debounced push-buttons and a
//   multiplexed 4-digit 7-segment display.
//
// Ports
//   clk        in   system clock, all state on its rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_start  in   start / pause / acknowledge button (async, active-high)
//   btn_dec    in   decrement-minute button (async, active-high)
//   btn_inc    in   increment-minute button (async, active-high)
//   btn_clr    in   clear button (async, active-high)
//   hold       in   suppresses all button events, holds debouncers cleared
//   an[3:0]    out  digit anodes, active-low, an[3] is the leftmost digit
//   seg[6:0]   out  cathodes {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   running    out  high while counting down
//   expired    out  high once the count has reached 00:00
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | stopped, minutes editable, no decimal point shown
// RUN     | prescaler running, one-second ticks decrement the time
// PAUSE   | stopped mid-count, minutes editable, prescaler cleared
// EXPIRED | count reached 00:00, display blinks until start or clr

module countdown_timer_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int MAX_MIN      = 99,
  parameter int DB_CYCLES    = 1_000_000,
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_dec,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       running,
  output logic       expired
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF    = (CLK_HZ >= 2) ? CLK_HZ / 2 : 1;
  localparam int BLK_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_e;

  // Button index: 3 clr, 2 start, 1 inc, 0 dec
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] db_lvl_q;
  logic [3:0] ev_q;
  logic [DB_W-1:0] db_cnt_q [4];

  assign btn_raw = {btn_clr, btn_start, btn_inc, btn_dec};

  // The counter tracks how many consecutive samples have differed from the
  // accepted level; the new level is taken on the DB_CYCLES-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_lvl_q <= '0;
      ev_q     <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      ev_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        if (hold) begin
          db_lvl_q[i] <= 1'b0;
          db_cnt_q[i] <= '0;
        end else if (sync2_q[i] == db_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_lvl_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
          ev_q[i]     <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A pulse already registered when hold rises is masked as well.
  logic ev_clr, ev_start, ev_inc, ev_dec;
  assign ev_clr   = ev_q[3] & ~hold;
  assign ev_start = ev_q[2] & ~hold;
  assign ev_inc   = ev_q[1] & ~hold;
  assign ev_dec   = ev_q[0] & ~hold;

  state_e             state_q;
  logic [6:0]         min_q;
  logic [5:0]         sec_q;
  logic [PRESC_W-1:0] presc_q;
  logic               running_q, expired_q;
  logic               tick, time_nz;

  assign tick    = (state_q == S_RUN) && (presc_q == PRESC_W'(CLK_HZ - 1));
  assign time_nz = (min_q != '0) || (sec_q != '0);

  // Events take precedence over the tick: a start or clr landing on a tick
  // cycle wins and that tick is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      presc_q <= '0;
      if (ev_clr) begin
        state_q   <= S_IDLE;
        min_q     <= '0;
        sec_q     <= '0;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else if (ev_start) begin
        case (state_q)
          S_IDLE, S_PAUSE: begin
            if (time_nz) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          S_RUN: begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end
          S_EXPIRED: begin
            state_q   <= S_IDLE;
            expired_q <= 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          S_IDLE, S_PAUSE: begin
            if (ev_inc) begin
              if (min_q < 7'(MAX_MIN)) min_q <= min_q + 1'b1;
            end else if (ev_dec) begin
              if (min_q != '0) min_q <= min_q - 1'b1;
            end
          end
          S_RUN: begin
            if (tick) begin
              if (sec_q != '0) begin
                sec_q <= sec_q - 1'b1;
                if ((sec_q == 6'd1) && (min_q == '0)) begin
                  state_q   <= S_EXPIRED;
                  running_q <= 1'b0;
                  expired_q <= 1'b1;
                end
              end else begin
                min_q <= min_q - 1'b1;
                sec_q <= 6'd59;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign running = running_q;
  assign expired = expired_q;

  logic [REFRESH_BITS-1:0] refr_q;
  logic [1:0]              dig_q;
  logic [BLK_W-1:0]        blink_cnt_q;
  logic                    blink_q;
  logic [3:0]              an_q, an_d, digit;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    digit = '0;
    an_d  = 4'b0111;
    case (dig_q)
      2'd0: begin digit = 4'(min_q / 7'd10); an_d = 4'b0111; end
      2'd1: begin digit = 4'(min_q % 7'd10); an_d = 4'b1011; end
      2'd2: begin digit = 4'(sec_q / 6'd10); an_d = 4'b1101; end
      default: begin digit = 4'(sec_q % 6'd10); an_d = 4'b1110; end
    endcase
    if ((state_q == S_EXPIRED) && !blink_q) an_d = 4'b1111;
    seg_d = seg_of(digit);
    dp_d  = !((dig_q == 2'd1) && (state_q != S_IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refr_q      <= '0;
      dig_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      an_q        <= 4'b0111;
      seg_q       <= 7'b1000000;
      dp_q        <= 1'b1;
    end else begin
      refr_q <= refr_q + 1'b1;
      if (refr_q == '1) dig_q <= dig_q + 1'b1;
      if (state_q == S_EXPIRED) begin
        if (blink_cnt_q == BLK_W'(HALF - 1)) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end else begin
        blink_cnt_q <= '0;
        blink_q     <= 1'b0;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl
//   Directed and randomised checks of countdown_timer_ctrl against a
//   behavioural model that keeps the remaining time as a count of seconds.

module tb_countdown_timer_ctrl;

  localparam int CLK_HZ = 10;
  localparam int MAXM   = 99;
  localparam int B_DEC = 0, B_INC = 1, B_START = 2, B_CLR = 3;
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = '0;
  logic       hold = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, running, expired;

  int total = 0;
  int passed = 0;
  int m = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(
    .CLK_HZ(CLK_HZ), .MAX_MIN(MAXM), .DB_CYCLES(2), .REFRESH_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn[B_START]), .btn_dec(btn[B_DEC]),
    .btn_inc(btn[B_INC]), .btn_clr(btn[B_CLR]), .hold(hold),
    .an(an), .seg(seg), .dp(dp), .running(running), .expired(expired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    step(5);
    btn[b] = 1'b0;
    step(5);
  endtask

  function automatic int dec_seg(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s === SEG_LUT[i]) return i;
    return 15;
  endfunction

  function automatic int dut_secs();
    return int'(dut.min_q) * 60 + int'(dut.sec_q);
  endfunction

  // Scan one full refresh period and rebuild the displayed time in seconds.
  task automatic read_display(output int t, output logic dpm);
    int d [4];
    logic [3:0] seen;
    seen = '0;
    dpm = 1'bx;
    for (int i = 0; i < 4; i++) d[i] = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      case (an)
        4'b0111: begin d[0] = dec_seg(seg); seen[0] = 1'b1; end
        4'b1011: begin d[1] = dec_seg(seg); seen[1] = 1'b1; dpm = dp; end
        4'b1101: begin d[2] = dec_seg(seg); seen[2] = 1'b1; end
        4'b1110: begin d[3] = dec_seg(seg); seen[3] = 1'b1; end
        default: ;
      endcase
    end
    t = (&seen) ? (d[0] * 10 + d[1]) * 60 + d[2] * 10 + d[3] : -1;
  endtask

  // Returns aligned on the cycle where running first reads high.
  task automatic start_align();
    int c;
    c = 0;
    btn[B_START] = 1'b1;
    while (running !== 1'b1 && c < 50) begin step(1); c++; end
    btn[B_START] = 1'b0;
    check("run_entered", running, 1'b1);
  endtask

  task automatic pause_count(output int k);
    k = 0;
    btn[B_START] = 1'b1;
    while (running !== 1'b0 && k < 50) begin step(1); k++; end
    btn[B_START] = 1'b0;
    check("pause_entered", running, 1'b0);
  endtask

  initial begin
    int t, k, tot;
    logic dpm;
    logic b [30];
    int f, bad, nblank;

    step(3);
    check("rst_an", an, 4'b0111);
    check("rst_seg", seg, 7'b1000000);
    check("rst_dp", dp, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_expired", expired, 1'b0);
    rst_n = 1'b1;
    step(2);

    // two minutes, first tick exactly CLK_HZ cycles after entering RUN
    repeat (2) begin press(B_INC); m = (m < MAXM) ? m + 1 : MAXM; end
    read_display(t, dpm);
    check("inc2_disp", t, m * 60);
    check("idle_dp", dpm, 1'b1);
    start_align();
    step(CLK_HZ - 1);
    check("pre_tick", dut_secs(), m * 60);
    step(1);
    check("first_tick", dut_secs(), m * 60 - 1);
    pause_count(k);
    tot = CLK_HZ + k;
    read_display(t, dpm);
    check("pause_disp", t, m * 60 - (tot - 1) / CLK_HZ);
    check("pause_dp", dpm, 1'b0);
    press(B_CLR); m = 0;
    read_display(t, dpm);
    check("clr_disp", t, 0);

    // one minute to expiry, blink, acknowledge
    press(B_INC); m = 1;
    start_align();
    step(60 * CLK_HZ - 1);
    check("pre_expire_secs", dut_secs(), 1);
    check("pre_expire_flag", expired, 1'b0);
    step(1);
    check("expire_secs", dut_secs(), 0);
    check("expire_flag", expired, 1'b1);
    check("expire_running", running, 1'b0);
    for (int i = 0; i < 30; i++) begin step(1); b[i] = (an === 4'b1111); end
    f = 1;
    while (f < 6 && b[f] == b[f - 1]) f++;
    check("blink_first_edge", (f <= 5), 1'b1);
    bad = 0;
    nblank = 0;
    for (int i = 0; i < 20; i++) begin
      if (b[f + i] != (b[f] ^ (((i / (CLK_HZ / 2)) % 2) == 1))) bad++;
      if (b[i]) nblank++;
    end
    check("blink_period", bad, 0);
    check("blink_duty", nblank, 10);
    press(B_START); m = 0;
    check("ack_expired", expired, 1'b0);
    check("ack_running", running, 1'b0);
    read_display(t, dpm);
    check("ack_disp", t, 0);

    // saturation, no wrap, start ignored at 00:00
    repeat (100) begin press(B_INC); m = (m < MAXM) ? m + 1 : MAXM; end
    read_display(t, dpm);
    check("inc_sat", t, MAXM * 60);
    repeat (100) begin press(B_DEC); m = (m > 0) ? m - 1 : 0; end
    read_display(t, dpm);
    check("dec_floor", t, 0);
    press(B_START);
    step(10);
    check("start_at_zero", running, 1'b0);

    // randomised setups and run lengths, hold randomly raised while running
    for (int it = 0; it < 4; it++) begin
      int ni, nd, r;
      ni = $urandom_range(0, 4);
      nd = $urandom_range(0, 3);
      repeat (ni) begin press(B_INC); m = (m < MAXM) ? m + 1 : MAXM; end
      repeat (nd) begin press(B_DEC); m = (m > 0) ? m - 1 : 0; end
      read_display(t, dpm);
      check("rnd_setup", t, m * 60);
      if (m == 0) begin
        press(B_START);
        check("rnd_zero_start", running, 1'b0);
      end else begin
        start_align();
        hold = 1'($urandom_range(0, 1));
        r = $urandom_range(15, 150);
        step(r);
        hold = 1'b0;
        check("rnd_run", dut_secs(), m * 60 - r / CLK_HZ);
        pause_count(k);
        tot = r + k;
        read_display(t, dpm);
        check("rnd_pause_disp", t, m * 60 - (tot - 1) / CLK_HZ);
      end
      press(B_CLR); m = 0;
    end

    // clr and start in the same cycle while running
    press(B_INC); m = 1;
    start_align();
    step(20);
    btn[B_CLR] = 1'b1;
    btn[B_START] = 1'b1;
    k = 0;
    while (running !== 1'b0 && k < 50) begin step(1); k++; end
    btn = '0;
    m = 0;
    check("clr_start_running", running, 1'b0);
    read_display(t, dpm);
    check("clr_start_disp", t, 0);
    check("clr_start_expired", expired, 1'b0);

    // short bounces are rejected, hold suppresses a real press
    repeat (3) begin press(B_INC); m = (m < MAXM) ? m + 1 : MAXM; end
    repeat (4) begin btn[B_INC] = 1'b1; step(1); btn[B_INC] = 1'b0; step(3); end
    step(5);
    read_display(t, dpm);
    check("bounce_reject", t, m * 60);
    hold = 1'b1;
    press(B_INC);
    hold = 1'b0;
    step(5);
    read_display(t, dpm);
    check("hold_suppress", t, m * 60);

    // asynchronous reset mid-run
    start_align();
    step(25);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_an", an, 4'b0111);
    check("arst_seg", seg, 7'b1000000);
    check("arst_dp", dp, 1'b1);
    check("arst_running", running, 1'b0);
    check("arst_expired", expired, 1'b0);
    step(1);
    rst_n = 1'b1;
    m = 0;
    step(30);
    check("post_rst_running", running, 1'b0);
    read_display(t, dpm);
    check("post_rst_disp", t, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
